// File: rtl/toggle_decoder_pkg.sv
// ----------------------------------------------------------------------------
// toggle_decoder_pkg
// Shared types and constants for the toggle-encoded serial decoder.
//   td_state_e    : frame FSM state encoding
//   DefaultWidth  : default number of data bits per word
// Build option: TOGGLE_DECODER_PARITY_EN adds the parity state.
// ----------------------------------------------------------------------------
package toggle_decoder_pkg;

    localparam int unsigned DefaultWidth = 8;

`ifdef TOGGLE_DECODER_PARITY_EN
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StData = 2'd1,
        StPar  = 2'd2
    } td_state_e;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StData = 2'd1
    } td_state_e;
`endif

endpackage

// File: rtl/toggle_decoder_t_edge_decode.sv
// ----------------------------------------------------------------------------
// t_edge_decode
// Recovers the toggle bit from a T flip-flop style line: a change of level
// between consecutive strobed samples is a 1, no change is a 0.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   q_in, q_stb  : serial line and its sample strobe
//   t_bit        : decoded bit (valid when t_stb=1)
//   t_stb        : strobe for t_bit, same cycle as q_stb
// ----------------------------------------------------------------------------
module t_edge_decode (
    input  logic clk,
    input  logic reset_n,
    input  logic q_in,
    input  logic q_stb,
    output logic t_bit,
    output logic t_stb
);

    logic r_q_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q_prev <= 1'b0;
        end else if (q_stb) begin
            r_q_prev <= q_in;
        end
    end

    assign t_bit = q_in ^ r_q_prev;
    assign t_stb = q_stb;

endmodule

// File: rtl/toggle_decoder.sv
// ----------------------------------------------------------------------------
// toggle_decoder
// Decodes toggle-encoded serial frames (start bit, WIDTH data bits LSB-first,
// optional even-parity bit) into words presented with a valid/ready output.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   q_in, q_stb  : toggle-encoded line and sample strobe
//   out_data     : last accepted word
//   out_valid    : out_data not yet consumed
//   out_ready    : consumer handshake
//   overrun      : sticky, a completed word was dropped during a stall
//   par_err      : parity mismatch of the word in out_data (0 without parity)
// Build option: define TOGGLE_DECODER_PARITY_EN to add the parity bit/state.
// ----------------------------------------------------------------------------
module toggle_decoder
    import toggle_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             q_in,
    input  logic             q_stb,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             par_err
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic             w_t_bit;
    logic             w_t_stb;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_word;
    logic             w_done;

    td_state_e        r_state;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    t_edge_decode u_t_edge_decode (
        .clk     (clk),
        .reset_n (reset_n),
        .q_in    (q_in),
        .q_stb   (q_stb),
        .t_bit   (w_t_bit),
        .t_stb   (w_t_stb)
    );

    // LSB-first: new bits enter at the MSB and drift down, so after WIDTH
    // shifts the first data bit sits in bit 0.
    always_comb begin
        w_shift_nxt            = r_shift >> 1;
        w_shift_nxt[WIDTH-1]   = w_t_bit;
    end

`ifdef TOGGLE_DECODER_PARITY_EN
    logic w_perr;
    logic r_par_err;

    // Word completes on the parity sample; data is already fully shifted in.
    always_comb begin
        w_done = w_t_stb && (r_state == StPar);
        w_word = r_shift;
        w_perr = (^r_shift) ^ w_t_bit;
    end
`else
    // Word completes on the last data sample; take the shifted value directly.
    always_comb begin
        w_done = w_t_stb && (r_state == StData) && (r_cnt == CntLast);
        w_word = w_shift_nxt;
    end
`endif

    // Frame FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_t_stb) begin
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (w_t_bit) begin
                        r_state <= StData;
                    end
                end
                StData: begin
                    r_shift <= w_shift_nxt;
                    if (r_cnt == CntLast) begin
                        r_cnt <= '0;
`ifdef TOGGLE_DECODER_PARITY_EN
                        r_state <= StPar;
`else
                        r_state <= StIdle;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef TOGGLE_DECODER_PARITY_EN
                StPar: begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
`endif
                default: begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Output holding register. A completing word is accepted only if the
    // slot is free or being drained this same edge; otherwise it is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_done) begin
            if (!r_valid || out_ready) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef TOGGLE_DECODER_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par_err <= 1'b0;
        end else if (w_done && (!r_valid || out_ready)) begin
            r_par_err <= w_perr;
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_toggle_decoder.sv
// ----------------------------------------------------------------------------
// tb_toggle_decoder
// Directed scenarios plus randomized line traffic, every cycle compared with
// a frame-level reference model (bit list -> word arithmetic).
// Honours TOGGLE_DECODER_PARITY_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_toggle_decoder;

    localparam int unsigned WIDTH = 8;
`ifdef TOGGLE_DECODER_PARITY_EN
    localparam int unsigned ParEn = 1;
`else
    localparam int unsigned ParEn = 0;
`endif
    localparam int unsigned Frame = WIDTH + ParEn;

    logic             clk;
    logic             reset_n;
    logic             q_in;
    logic             q_stb;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             par_err;

    int n_checks;
    int n_fail;

    // Reference model state
    bit             m_qprev;
    bit             m_inframe;
    int             m_bits[$];
    bit [WIDTH-1:0] m_data;
    bit             m_valid;
    bit             m_ovr;
    bit             m_perr;

    toggle_decoder #(
        .WIDTH (WIDTH)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .q_in      (q_in),
        .q_stb     (q_stb),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .par_err   (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".data"},    32'(out_data),  32'(m_data));
        check({tag, ".valid"},   32'(out_valid), 32'(m_valid));
        check({tag, ".overrun"}, 32'(overrun),   32'(m_ovr));
        check({tag, ".par_err"}, 32'(par_err),   32'(m_perr));
    endtask

    task automatic model_reset();
        m_qprev   = 1'b0;
        m_inframe = 1'b0;
        m_bits.delete();
        m_data    = '0;
        m_valid   = 1'b0;
        m_ovr     = 1'b0;
        m_perr    = 1'b0;
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input bit q, input bit stb, input bit rdy);
        bit             done;
        bit [WIDTH-1:0] word;
        int             ones;
        int             t;
        done = 1'b0;
        word = '0;
        ones = 0;
        if (stb) begin
            t       = int'(q ^ m_qprev);
            m_qprev = q;
            if (!m_inframe) begin
                if (t == 1) begin
                    m_inframe = 1'b1;
                    m_bits.delete();
                end
            end else begin
                m_bits.push_back(t);
                if (m_bits.size() == Frame) begin
                    done = 1'b1;
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        if (m_bits[i] != 0) word[i] = 1'b1;
                    end
                    for (int i = 0; i < int'(Frame); i++) ones += m_bits[i];
                    m_inframe = 1'b0;
                end
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_data  = word;
                m_valid = 1'b1;
                m_perr  = (ParEn != 0) && (ones % 2 == 1);
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input bit q, input bit stb, input bit rdy, input string tag);
        @(negedge clk);
        q_in      = q;
        q_stb     = stb;
        out_ready = rdy;
        @(posedge clk);
        model_edge(q, stb, rdy);
        #1;
        compare_all(tag);
    endtask

    // Drive the line so the decoded bit is t.
    task automatic send_t(input bit t, input bit rdy);
        step(m_qprev ^ t, 1'b1, rdy, "bit");
    endtask

    task automatic send_word(input bit [WIDTH-1:0] w, input bit flip, input bit rdy,
                             input bit rdy_last);
        bit last;
        send_t(1'b1, rdy);
        for (int i = 0; i < int'(WIDTH); i++) begin
            last = (i == int'(WIDTH) - 1) && (ParEn == 0);
            send_t(w[i], last ? rdy_last : rdy);
        end
        if (ParEn != 0) send_t((^w) ^ flip, rdy_last);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n   = 1'b0;
        q_in      = 1'b0;
        q_stb     = 1'b0;
        out_ready = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b1;
        q_in      = 1'b0;
        q_stb     = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // Reset state
        do_reset("reset");
        check("reset.data_zero", 32'(out_data), 32'h0);

        // Basic word 0xA5
        send_word(8'hA5, 1'b0, 1'b0, 1'b0);
        check("a5.data", 32'(out_data), 32'hA5);
        check("a5.valid", 32'(out_valid), 32'h1);
        check("a5.par_err", 32'(par_err), 32'h0);
        step(m_qprev, 1'b0, 1'b1, "a5.drain");
        check("a5.drained", 32'(out_valid), 32'h0);

`ifdef TOGGLE_DECODER_PARITY_EN
        // Bad parity bit on the same word
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        check("a5bad.data", 32'(out_data), 32'hA5);
        check("a5bad.par_err", 32'(par_err), 32'h1);
        step(m_qprev, 1'b0, 1'b1, "a5bad.drain");
`endif

        // Back-to-back words during a stall
        do_reset("reset2");
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b0, 1'b0);
        check("ovr.data", 32'(out_data), 32'h3C);
        check("ovr.flag", 32'(overrun), 32'h1);
        step(m_qprev, 1'b0, 1'b1, "ovr.drain");
        check("ovr.cleared", 32'(out_valid), 32'h0);
        check("ovr.sticky", 32'(overrun), 32'h1);

        // Completion on the handshake edge
        do_reset("reset3");
        send_word(8'h12, 1'b0, 1'b0, 1'b0);
        send_word(8'h34, 1'b0, 1'b0, 1'b1);
        check("hs.data", 32'(out_data), 32'h34);
        check("hs.valid", 32'(out_valid), 32'h1);
        check("hs.overrun", 32'(overrun), 32'h0);

        // Reset mid-word, then a fresh word
        do_reset("reset4");
        send_t(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_t(1'(i), 1'b0);
        do_reset("midreset");
        check("midreset.valid", 32'(out_valid), 32'h0);
        send_word(8'h0F, 1'b0, 1'b0, 1'b0);
        check("0f.data", 32'(out_data), 32'h0F);

        // Unstrobed toggling and idle zero samples
        do_reset("reset5");
        for (int i = 0; i < 10; i++) step(1'(i), 1'b0, 1'b0, "nostb");
        for (int i = 0; i < 10; i++) step(m_qprev, 1'b1, 1'b0, "idle0");
        check("idle.valid", 32'(out_valid), 32'h0);

        // Randomized traffic
        do_reset("reset6");
        for (int i = 0; i < 2500; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
